// File: rtl/counter_pkg.sv
// Shared types and constants for the counter command sequencer: opcodes,
// queued-command layout, FSM states and the counter width.
package counter_pkg;

   localparam int CNT_W    = 4;
   localparam int MAX_STEP = 3;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_INCR   = 2'b01,
      OP_DECR   = 2'b10,
      OP_REINIT = 2'b11
   } op_e;

   typedef struct packed {
      op_e              op;
      logic [CNT_W-1:0] amount;
      logic [CNT_W-1:0] init;
   } cmd_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } seq_state_e;

endpackage

// File: rtl/counter_cmd_sequencer_if.sv
// Upstream command handshake: valid/ready plus the command payload.
interface counter_cmd_sequencer_if;
   import counter_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_amount;
   logic [CNT_W-1:0] cmd_init;

   modport master (output cmd_valid, cmd_op, cmd_amount, cmd_init, input cmd_ready);
   modport slave  (input cmd_valid, cmd_op, cmd_amount, cmd_init, output cmd_ready);

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous first-in first-out command queue with valid/ready push, pop/empty
// read side and a synchronous clear that wins over a concurrent push or pop.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_i,
   input  logic                   push_valid_i,
   output logic                   push_ready_o,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       pop_data_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push;
   logic             pop;

   assign push_ready_o = (count_q < CW'(DEPTH));
   assign empty_o      = (count_q == '0);
   assign push         = push_valid_i && push_ready_o && !clear_i;
   assign pop          = pop_i && !empty_o && !clear_i;
   assign pop_data_o   = mem_q[rd_ptr_q];
   assign count_o      = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap naturally
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Queues counter commands and expands each into registered per-cycle beats
// (incr/decr chunks of at most MAX_STEP, or a single reinit beat).
module counter_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_STEP   = counter_pkg::MAX_STEP
) (
   input  logic                               clk,
   input  logic                               rst,
   counter_cmd_sequencer_if.slave             cmd,
   input  logic                               hold,
   input  logic                               flush,
   output logic                               reinit,
   output logic [counter_pkg::CNT_W-1:0]      initial_value,
   output logic                               incr_valid,
   output logic [1:0]                         incr,
   output logic                               decr_valid,
   output logic [1:0]                         decr,
   output logic                               busy,
   output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

   import counter_pkg::*;

   localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(MAX_STEP);

   function automatic logic [CNT_W-1:0] clamp_step(input logic [CNT_W-1:0] rem);
      return (rem > STEP_MAX) ? STEP_MAX : rem;
   endfunction

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   op_e              op_q;
   logic [CNT_W-1:0] init_q;
   logic             reinit_q, reinit_d;
   logic [CNT_W-1:0] init_val_q, init_val_d;
   logic             incr_valid_q, incr_valid_d;
   logic [1:0]       incr_q, incr_d;
   logic             decr_valid_q, decr_valid_d;
   logic [1:0]       decr_q, decr_d;

   logic [CNT_W-1:0] step;
   logic             cmd_done;
   logic             load;
   logic             fifo_empty;
   logic             fifo_ready;
   cmd_t             head;
   logic [$clog2(FIFO_DEPTH):0] count;

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(cmd_t))
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (flush),
      .push_valid_i (cmd.cmd_valid),
      .push_ready_o (fifo_ready),
      .push_data_i  ({cmd.cmd_op, cmd.cmd_amount, cmd.cmd_init}),
      .pop_i        (load),
      .pop_data_o   (head),
      .empty_o      (fifo_empty),
      .count_o      (count)
   );

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      load         = 1'b0;
      cmd_done     = 1'b0;
      step         = clamp_step(rem_q);
      reinit_d     = 1'b0;
      init_val_d   = '0;
      incr_valid_d = 1'b0;
      incr_d       = '0;
      decr_valid_d = 1'b0;
      decr_d       = '0;
      if (flush) begin
         state_d = ST_IDLE;
         rem_d   = '0;
      end else if (!hold) begin
         case (state_q)
            ST_IDLE: load = !fifo_empty;
            ST_ISSUE: begin
               case (op_q)
                  OP_INCR: begin
                     incr_valid_d = (step != '0);
                     incr_d       = step[1:0];
                  end
                  OP_DECR: begin
                     decr_valid_d = (step != '0);
                     decr_d       = step[1:0];
                  end
                  OP_REINIT: begin
                     reinit_d   = 1'b1;
                     init_val_d = init_q;
                  end
                  default: ;
               endcase
               rem_d    = rem_q - step;
               cmd_done = (op_q inside {OP_INCR, OP_DECR}) ? (rem_q <= STEP_MAX) : 1'b1;
               // Chain straight into the next queued command so there is no bubble
               if (cmd_done) begin
                  if (!fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     rem_d   = '0;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
         if (load) begin
            state_d = ST_ISSUE;
            rem_d   = head.amount;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rem_q        <= '0;
         reinit_q     <= 1'b0;
         init_val_q   <= '0;
         incr_valid_q <= 1'b0;
         incr_q       <= '0;
         decr_valid_q <= 1'b0;
         decr_q       <= '0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         reinit_q     <= reinit_d;
         init_val_q   <= init_val_d;
         incr_valid_q <= incr_valid_d;
         incr_q       <= incr_d;
         decr_valid_q <= decr_valid_d;
         decr_q       <= decr_d;
      end
   end

   // Loaded opcode/init are only consulted in ISSUE, so they need no reset
   always_ff @(posedge clk) begin
      if (load) begin
         op_q   <= head.op;
         init_q <= head.init;
      end
   end

   assign cmd.cmd_ready  = fifo_ready;
   assign reinit         = reinit_q;
   assign initial_value  = init_val_q;
   assign incr_valid     = incr_valid_q;
   assign incr           = incr_q;
   assign decr_valid     = decr_valid_q;
   assign decr           = decr_q;
   assign busy           = (state_q == ST_ISSUE) || !fifo_empty;
   assign fifo_count     = count;

endmodule
